// File: rtl/sm510_pkg.sv
// sm510_pkg: shared constants, fetch phases and program-counter helpers for the sm510 core
package sm510_pkg;
    localparam logic [11:0] RESET_PC = 12'hFC0;
    localparam logic [7:0] OP_SBM = 8'h02;
    localparam logic [7:0] OP_LBL = 8'h5F;
    typedef enum logic [1:0] {FETCH, SECOND, VECTOR} phase_t;
    function automatic logic [5:0] pl_next(input logic [5:0] pl);
        return {pl[0] == pl[1], pl[5:1]};
    endfunction
    function automatic logic two_byte(input logic [7:0] op);
        return op[7:4] == 4'h7 || op == OP_LBL;
    endfunction
    function automatic logic is_tml(input logic [7:0] op);
        return op[7:2] == 6'b011111;
    endfunction
endpackage

// File: rtl/sm510_ram.sv
// sm510_ram: 128x4 data RAM, synchronous write and asynchronous read, never cleared
module sm510_ram (
    input  logic       clk,
    input  logic       we,
    input  logic [6:0] addr,
    input  logic [3:0] wdata,
    output logic [3:0] rdata
);
    logic [3:0] ram [128];
    always_ff @(posedge clk)
        if (we) ram[addr] <= wdata;
    assign rdata = ram[addr];
endmodule

// File: rtl/sm510.sv
// sm510: Sharp SM510 4-bit CPU core, one ROM byte consumed per clk_en
module sm510
    import sm510_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic [7:0]  rom_data,
    output logic [11:0] rom_addr,
    input  logic [3:0]  input_k,
    input  logic        input_ba,
    input  logic        input_beta
);
    logic [1:0] pu;
    logic [3:0] pm;
    logic [5:0] pl;
    logic [3:0] acc, bl, m, wdata, mask;
    logic [2:0] bm;
    logic [11:0] s, r, ret;
    logic [7:0] w, op1;
    logic [14:0] div;
    logic [4:0] sum11, adx;
    logic c, gamma, skip, disc, sbm, lax, exec, we;
    phase_t phase;

    sm510_ram ram (
        .clk(clk),
        .we(we),
        .addr({bm[2] | sbm, bm[1:0], bl}),
        .wdata(wdata),
        .rdata(m)
    );

    assign rom_addr = {pu, pm, pl};

    always_comb begin
        exec = clk_en && phase == FETCH && !skip;
        ret = {pu, pm, pl_next(pl)};
        mask = 4'b0001 << rom_data[1:0];
        sum11 = {1'b0, acc} + {1'b0, m} + {4'd0, c};
        adx = {1'b0, acc} + {1'b0, rom_data[3:0]};
        we = exec && (rom_data inside {[8'h04:8'h07], [8'h0C:8'h17], [8'h1C:8'h1F]});
        wdata = rom_data[7:2] == 6'h01 ? m & ~mask : rom_data[7:2] == 6'h03 ? m | mask : acc;
    end

    // later assignments in the decode override the default Pl advance, divider count and gamma set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {pu, pm, pl} <= RESET_PC;
            acc <= '0;
            c <= 1'b0;
            bm <= '0;
            bl <= '0;
            s <= '0;
            r <= '0;
            w <= '0;
            div <= '0;
            gamma <= 1'b0;
            skip <= 1'b0;
            disc <= 1'b0;
            sbm <= 1'b0;
            lax <= 1'b0;
            op1 <= '0;
            phase <= FETCH;
        end else if (clk_en) begin
            pl <= pl_next(pl);
            div <= div + 15'd1;
            if (div == '1) gamma <= 1'b1;
            case (phase)
                VECTOR: begin
                    {pu, pm, pl} <= {6'd0, rom_data[5:0]};
                    phase <= FETCH;
                end
                SECOND: begin
                    phase <= FETCH;
                    if (!disc && op1 == OP_LBL) {bm, bl} <= rom_data[6:0];
                    else if (!disc) begin
                        {pu, pm, pl} <= {rom_data[7:6], op1[3:0], rom_data[5:0]};
                        if (is_tml(op1)) begin
                            r <= s;
                            s <= ret;
                        end
                    end
                end
                default: begin
                    sbm <= 1'b0;
                    lax <= 1'b0;
                    skip <= 1'b0;
                    if (two_byte(rom_data)) begin
                        phase <= SECOND;
                        op1 <= rom_data;
                        disc <= skip;
                    end
                    if (!skip) begin
                        sbm <= rom_data == OP_SBM;
                        case (rom_data) inside
                            8'h08: acc <= acc + m;
                            8'h09: begin
                                {c, acc} <= sum11;
                                skip <= sum11[4];
                            end
                            8'h0A: acc <= ~acc;
                            8'h0B: begin
                                acc <= bl;
                                bl <= acc;
                            end
                            [8'h10:8'h13], [8'h18:8'h1B]: begin
                                acc <= m;
                                bm <= bm ^ {1'b0, rom_data[1:0]};
                            end
                            [8'h14:8'h17]: begin
                                acc <= m;
                                bm <= bm ^ {1'b0, rom_data[1:0]};
                                bl <= bl + 4'd1;
                                skip <= bl == 4'hF;
                            end
                            [8'h1C:8'h1F]: begin
                                acc <= m;
                                bm <= bm ^ {1'b0, rom_data[1:0]};
                                bl <= bl - 4'd1;
                                skip <= bl == 4'h0;
                            end
                            [8'h20:8'h2F]: begin
                                lax <= 1'b1;
                                if (!lax) acc <= rom_data[3:0];
                            end
                            [8'h30:8'h3F]: begin
                                acc <= adx[3:0];
                                skip <= adx[4] && rom_data[3:0] != 4'hA;
                            end
                            [8'h40:8'h4F]: begin
                                bm <= {1'b0, rom_data[3:2]};
                                bl <= {{2{|rom_data[1:0]}}, rom_data[1:0]};
                            end
                            8'h51: skip <= input_beta;
                            8'h52: skip <= !c;
                            8'h53: skip <= acc == m;
                            [8'h54:8'h57]: skip <= |(m & mask);
                            8'h58: begin
                                skip <= !gamma;
                                gamma <= 1'b0;
                            end
                            8'h5A: skip <= acc == 4'h0;
                            8'h5B: skip <= acc == bl;
                            8'h5E: skip <= input_ba;
                            8'h62, 8'h63: w <= (w << 1) | {7'd0, rom_data[0]};
                            8'h64: begin
                                bl <= bl + 4'd1;
                                skip <= bl == 4'hF;
                            end
                            8'h65: div <= '0;
                            8'h66: c <= 1'b0;
                            8'h67: c <= 1'b1;
                            8'h68: skip <= div[14];
                            8'h69: skip <= div[11];
                            8'h6A: acc <= input_k;
                            8'h6B: {acc, c} <= {c, acc};
                            8'h6C: begin
                                bl <= bl - 4'd1;
                                skip <= bl == 4'h0;
                            end
                            8'h6E, 8'h6F: begin
                                {pu, pm, pl} <= s;
                                s <= r;
                                skip <= rom_data[0];
                            end
                            [8'h80:8'hBF]: pl <= rom_data[5:0];
                            [8'hC0:8'hFF]: begin
                                r <= s;
                                s <= ret;
                                {pu, pm, pl} <= {6'd0, rom_data[5:0]};
                                phase <= VECTOR;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sm510.sv
// tb_sm510: scoreboard bench comparing sm510 fetch addresses and state with an instruction-level model
module tb_sm510;
    logic clk = 1'b0, reset = 1'b1, clk_en = 1'b0, input_ba = 1'b0, input_beta = 1'b0;
    logic [3:0] input_k = 4'h0;
    logic [7:0] rom_data;
    logic [11:0] rom_addr;
    logic [7:0] rom [4096];
    int exp_q [$];
    int errors = 0, checks = 0;
    int m_pc, m_acc, m_c, m_bm, m_bl, m_s, m_r, m_w, m_div, m_gamma, m_skip, m_sbm, m_lax, m_mode, m_disc, m_op1;
    int mem [128];

    sm510 dut (
        .clk(clk),
        .reset(reset),
        .clk_en(clk_en),
        .rom_data(rom_data),
        .rom_addr(rom_addr),
        .input_k(input_k),
        .input_ba(input_ba),
        .input_beta(input_beta)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (clk_en && !reset) begin
            #1;
            if (exp_q.size() == 0) chk("unexpected_step", 1, 0);
            else chk("rom_addr", rom_addr, exp_q.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int adv(input int pc);
        int pl = pc % 64;
        return pc - pl + ((pl % 2 == (pl / 2) % 2) ? 32 : 0) + pl / 2;
    endfunction

    task automatic ref_reset();
        m_pc = 'hFC0;
        {m_acc, m_c, m_bm, m_bl, m_s, m_r, m_w, m_div} = '0;
        {m_gamma, m_skip, m_sbm, m_lax, m_mode, m_disc, m_op1} = '0;
    endtask

    // one ROM byte of architectural behaviour; pushes the address the core must fetch next
    task automatic ref_step();
        int b, a, nxt, d0, t, x, laxp, tis;
        b = rom[m_pc];
        a = ((m_sbm != 0 || m_bm >= 4) ? 64 : 0) + (m_bm % 4) * 16 + m_bl;
        nxt = adv(m_pc);
        d0 = m_div;
        m_div = (d0 + 1) % 32768;
        tis = 0;
        if (m_mode == 2) begin
            nxt = b % 64;
            m_mode = 0;
        end else if (m_mode == 1) begin
            m_mode = 0;
            if (m_disc == 0 && m_op1 == 'h5F) begin
                m_bm = (b / 16) % 8;
                m_bl = b % 16;
            end else if (m_disc == 0) begin
                if (m_op1 % 16 >= 12) begin
                    m_r = m_s;
                    m_s = nxt;
                end
                nxt = (b / 64) * 1024 + (m_op1 % 16) * 64 + b % 64;
            end
        end else if (m_skip != 0) begin
            m_skip = 0;
            m_sbm = 0;
            m_lax = 0;
            if (b / 16 == 7 || b == 'h5F) begin
                m_mode = 1;
                m_op1 = b;
                m_disc = 1;
            end
        end else begin
            laxp = m_lax;
            m_sbm = int'(b == 2);
            m_lax = int'(b / 16 == 2);
            if (b / 16 == 7 || b == 'h5F) begin
                m_mode = 1;
                m_op1 = b;
                m_disc = 0;
            end else if (b >= 'hC0) begin
                m_r = m_s;
                m_s = nxt;
                nxt = b % 64;
                m_mode = 2;
            end else if (b >= 'h80) nxt = m_pc - m_pc % 64 + b % 64;
            else if (b >= 'h10 && b < 'h20) begin
                x = (b / 4) % 4;
                t = mem[a];
                if (x != 2) mem[a] = m_acc;
                m_acc = t;
                m_bm = m_bm ^ (b % 4);
                if (x == 1) begin
                    m_bl = (m_bl + 1) % 16;
                    m_skip = int'(m_bl == 0);
                end
                if (x == 3) begin
                    m_bl = (m_bl + 15) % 16;
                    m_skip = int'(m_bl == 15);
                end
            end else if (b / 16 == 2) begin
                if (laxp == 0) m_acc = b % 16;
            end else if (b / 16 == 3) begin
                t = m_acc + b % 16;
                m_acc = t % 16;
                m_skip = int'(t > 15 && b % 16 != 10);
            end else if (b / 16 == 4) begin
                m_bm = (b / 4) % 4;
                m_bl = (b % 4 == 0) ? 0 : 12 + b % 4;
            end else case (b)
                'h04, 'h05, 'h06, 'h07: mem[a] = mem[a] & (15 - (1 << (b % 4)));
                'h0C, 'h0D, 'h0E, 'h0F: mem[a] = mem[a] | (1 << (b % 4));
                'h08: m_acc = (m_acc + mem[a]) % 16;
                'h09: begin
                    t = m_acc + mem[a] + m_c;
                    m_acc = t % 16;
                    m_c = t / 16;
                    m_skip = m_c;
                end
                'h0A: m_acc = 15 - m_acc;
                'h0B: begin
                    t = m_acc;
                    m_acc = m_bl;
                    m_bl = t;
                end
                'h51: m_skip = int'(input_beta);
                'h52: m_skip = int'(m_c == 0);
                'h53: m_skip = int'(m_acc == mem[a]);
                'h54, 'h55, 'h56, 'h57: m_skip = (mem[a] >> (b % 4)) % 2;
                'h58: begin
                    m_skip = int'(m_gamma == 0);
                    tis = 1;
                end
                'h5A: m_skip = int'(m_acc == 0);
                'h5B: m_skip = int'(m_acc == m_bl);
                'h5E: m_skip = int'(input_ba);
                'h62, 'h63: m_w = (m_w * 2 + b % 2) % 256;
                'h64: begin
                    m_bl = (m_bl + 1) % 16;
                    m_skip = int'(m_bl == 0);
                end
                'h65: m_div = 0;
                'h66: m_c = 0;
                'h67: m_c = 1;
                'h68: m_skip = (d0 >> 14) % 2;
                'h69: m_skip = (d0 >> 11) % 2;
                'h6A: m_acc = int'(input_k);
                'h6B: begin
                    t = m_c;
                    m_c = m_acc % 2;
                    m_acc = m_acc / 2 + t * 8;
                end
                'h6C: begin
                    m_bl = (m_bl + 15) % 16;
                    m_skip = int'(m_bl == 15);
                end
                'h6E, 'h6F: begin
                    nxt = m_s;
                    m_s = m_r;
                    m_skip = int'(b == 'h6F);
                end
                default: ;
            endcase
        end
        if (tis != 0) m_gamma = 0;
        else if (d0 == 32767) m_gamma = 1;
        m_pc = nxt;
        exp_q.push_back(nxt);
    endtask

    task automatic pulse(input int gap);
        @(negedge clk) clk_en = 1'b1;
        @(negedge clk) clk_en = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic dstep(input int e);
        exp_q.push_back(e);
        pulse(2);
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        @(negedge clk) chk("reset_addr", rom_addr, 'hFC0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    endtask

    task automatic rand_run(input int steps);
        int diffs;
        for (int i = 0; i < 4096; i++) begin
            rom[i] = 8'($urandom);
            if (rom[i][7] && $urandom_range(0, 3) != 0) rom[i][7] = 1'b0;
            if (i < 64) rom[i] = rom[i] & 8'h3F;
        end
        for (int i = 0; i < 128; i++) begin
            mem[i] = $urandom_range(0, 15);
            dut.ram.ram[i] = 4'(mem[i]);
        end
        do_reset();
        ref_reset();
        for (int i = 0; i < steps; i++) begin
            input_k = 4'($urandom);
            input_beta = 1'($urandom);
            input_ba = 1'($urandom);
            ref_step();
            pulse($urandom_range(0, 2));
        end
        chk("acc", dut.acc, m_acc);
        chk("carry", dut.c, m_c);
        chk("bm", dut.bm, m_bm);
        chk("bl", dut.bl, m_bl);
        chk("stack_s", dut.s, m_s);
        chk("stack_r", dut.r, m_r);
        chk("w", dut.w, m_w);
        diffs = 0;
        for (int i = 0; i < 128; i++) if (dut.ram.ram[i] != 4'(mem[i])) diffs++;
        chk("ram_diff_count", diffs, 0);
    endtask

    initial begin
        clear_rom();
        do_reset();
        dstep('hFE0);
        dstep('hFF0);
        dstep('hFF8);
        dstep('hFFC);
        dstep('hFFE);
        dstep('hFDF);

        clear_rom();
        rom['hFC0] = 8'h25;
        rom['hFE0] = 8'h40;
        rom['hFF0] = 8'h10;
        dut.ram.ram[0] = 4'h0;
        do_reset();
        dstep('hFE0);
        dstep('hFF0);
        dstep('hFF8);
        chk("exc_ram0", dut.ram.ram[0], 5);
        chk("exc_acc", dut.acc, 0);

        clear_rom();
        rom['hFC0] = 8'h72;
        rom['hFE0] = 8'hA3;
        do_reset();
        dstep('hFE0);
        dstep('h8A3);

        clear_rom();
        rom['hFC0] = 8'h2F;
        rom['hFE0] = 8'h31;
        rom['hFF0] = 8'hAA;
        rom['hFF8] = 8'h40;
        rom['hFFC] = 8'h10;
        dut.ram.ram[0] = 4'h7;
        do_reset();
        dstep('hFE0);
        dstep('hFF0);
        dstep('hFF8);
        dstep('hFFC);
        dstep('hFFE);
        chk("adx_ram0", dut.ram.ram[0], 0);
        chk("adx_acc", dut.acc, 7);

        for (int v = 9; v >= 8; v--) begin
            clear_rom();
            rom['hFC0] = 8'(8'h20 + v);
            rom['hFE0] = 8'h40;
            rom['hFF0] = 8'h53;
            rom['hFF8] = 8'hAA;
            dut.ram.ram[0] = 4'h9;
            do_reset();
            dstep('hFE0);
            dstep('hFF0);
            dstep('hFF8);
            dstep(v == 9 ? 'hFFC : 'hFEA);
        end

        clear_rom();
        rom['hFC0] = 8'h6A;
        rom['hFE0] = 8'h40;
        rom['hFF0] = 8'h10;
        dut.ram.ram[0] = 4'h3;
        input_k = 4'hA;
        do_reset();
        dstep('hFE0);
        dstep('hFF0);
        dstep('hFF8);
        chk("kta_ram0", dut.ram.ram[0], 'hA);

        clear_rom();
        rom['hFC0] = 8'h72;
        do_reset();
        dstep('hFE0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("async_reset_addr", rom_addr, 'hFC0);
        rom['hFC0] = 8'h00;
        @(negedge clk) reset = 1'b0;
        repeat (2) @(negedge clk);
        dstep('hFE0);

        for (int n = 0; n < 5; n++) rand_run(400);
        rand_run(2600);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
